// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: opcode, func3 and FSM encodings shared by the load/store unit
package load_store_unit_pkg;
    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane steering, load extraction/extension and access legality
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic        is_store_i,
    input  logic [2:0]  func3_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    // size comes from func3[1:0]; unsigned variants only exist for loads
    always_comb begin
        byte_sel = rdata_i[8*addr_lo_i +: 8];
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        be_o     = func3_i[1:0] == 2'b00 ? 4'b0001 << addr_lo_i :
                   func3_i[1:0] == 2'b01 ? (addr_lo_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wdata_o  = func3_i[1:0] == 2'b00 ? {4{wdata_i[7:0]}} :
                   func3_i[1:0] == 2'b01 ? {2{wdata_i[15:0]}} : wdata_i;
        rdata_o  = func3_i == F3_LB  ? {{24{byte_sel[7]}}, byte_sel} :
                   func3_i == F3_LH  ? {{16{half_sel[15]}}, half_sel} :
                   func3_i == F3_LW  ? rdata_i :
                   func3_i == F3_LBU ? {24'd0, byte_sel} :
                   func3_i == F3_LHU ? {16'd0, half_sel} : 32'd0;
        err_o    = func3_i == 3'b011 || func3_i[2:1] == 2'b11 || (is_store_i && func3_i[2]) ||
                   (func3_i[1:0] == 2'b01 && addr_lo_i[0]) ||
                   (func3_i[1:0] == 2'b10 && addr_lo_i != 2'b00);
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding LOAD/STORE memory stage with one-cycle response
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  opcode,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    input  logic        flush
);
    state_e      state_q, state_d;
    logic        store_q, kill_q, kill_d, err_q, err_d;
    logic [2:0]  func3_q;
    logic [31:0] addr_q, wdata_q, rdata_q, rdata_d;
    logic [4:0]  rd_q;
    logic        idle, in_req, in_resp, accept;
    logic        al_store, al_err;
    logic [2:0]  al_func3;
    logic [1:0]  al_addr;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, al_rdata;

    assign idle    = state_q == S_IDLE;
    assign in_req  = state_q == S_REQ;
    assign in_resp = state_q == S_RESP;
    assign accept  = idle && req_valid && (opcode == OP_LOAD || opcode == OP_STORE);
    // legality is judged on the incoming request in IDLE, lanes/extraction on the latched one afterwards
    assign al_store = idle ? opcode == OP_STORE : store_q;
    assign al_func3 = idle ? func3 : func3_q;
    assign al_addr  = idle ? addr[1:0] : addr_q[1:0];

    lsu_align u_align (
        .is_store_i (al_store),
        .func3_i    (al_func3),
        .addr_lo_i  (al_addr),
        .wdata_i    (wdata_q),
        .rdata_i    (mem_rdata),
        .be_o       (al_be),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .err_o      (al_err)
    );

    // state, kill flag, response data and the accepted request fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            store_q <= 1'b0;
            func3_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (accept) begin
                store_q <= opcode == OP_STORE;
                func3_q <= func3;
                addr_q  <= addr;
                wdata_q <= wdata;
                rd_q    <= rd;
            end
        end
    end

    // a granted load must still drain its rvalid, so flush only marks it killed
    always_comb begin
        state_d = state_q;
        kill_d  = kill_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            S_IDLE: if (accept) begin
                err_d   = al_err;
                rdata_d = '0;
                kill_d  = 1'b0;
                state_d = al_err ? S_RESP : S_REQ;
            end
            S_REQ: if (mem_gnt) begin
                state_d = store_q ? S_RESP : S_WAIT;
                kill_d  = flush && !store_q;
            end else if (flush) begin
                state_d = S_IDLE;
            end
            S_WAIT: if (mem_rvalid) begin
                state_d = (kill_q || flush) ? S_IDLE : S_RESP;
                rdata_d = al_rdata;
            end else if (flush) begin
                kill_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign req_ready  = idle;
    assign mem_req    = in_req;
    assign mem_we     = in_req && store_q;
    assign mem_be     = in_req ? al_be : 4'd0;
    assign mem_addr   = in_req ? {addr_q[31:2], 2'b00} : 32'd0;
    assign mem_wdata  = in_req && store_q ? al_wdata : 32'd0;
    assign resp_valid = in_resp;
    assign resp_rdata = in_resp ? rdata_q : 32'd0;
    assign resp_rd    = in_resp ? rd_q : 5'd0;
    assign resp_err   = in_resp && err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for the load/store unit
module tb_load_store_unit;
    localparam logic [4:0] LD = 5'b00000;
    localparam logic [4:0] ST = 5'b01000;

    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready;
    logic [4:0]  opcode = 0, rd = 0;
    logic [2:0]  func3 = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_gnt = 0, mem_rvalid = 0, flush = 0;
    logic [31:0] mem_rdata = 0;

    typedef struct {
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .func3(func3), .addr(addr), .wdata(wdata), .rd(rd),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .flush(flush)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // monitor: every response must match the oldest expectation, including its cycle
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected got rdata=%h rd=%0d err=%b cyc=%0d", resp_rdata, resp_rd, resp_err, cyc);
                end else begin
                    e = sb.pop_front();
                    if (resp_rdata !== e.rdata || resp_rd !== e.rd || resp_err !== e.err || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL resp got rdata=%h rd=%0d err=%b cyc=%0d exp rdata=%h rd=%0d err=%b cyc=%0d",
                                 resp_rdata, resp_rd, resp_err, cyc, e.rdata, e.rd, e.err, e.cyc);
                    end
                end
            end else if (resp_rdata !== 0 || resp_rd !== 0 || resp_err !== 0) begin
                errors++;
                $display("FAIL resp_idle_zero got rdata=%h rd=%0d err=%b exp 0", resp_rdata, resp_rd, resp_err);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] r, input logic [4:0] t, input logic er, input int lat);
        sb.push_back('{r, t, er, cyc + lat});
    endtask

    task automatic issue(input logic [4:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] w, input logic [4:0] t);
        req_valid = 1; opcode = op; func3 = f3; addr = a; wdata = w; rd = t;
        chk("req_ready_at_issue", {31'd0, req_ready}, 1);
        step;
        req_valid = 0; opcode = 0; func3 = 0; addr = 0; wdata = 0; rd = 0;
    endtask

    task automatic load_fast(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] t,
                             input logic [31:0] raw, input logic [31:0] exp);
        push(exp, t, 0, 3);
        issue(LD, f3, a, 0, t);
        chk("load_we", {31'd0, mem_we}, 0);
        chk("load_addr", mem_addr, {a[31:2], 2'b00});
        mem_gnt = 1;
        step;
        mem_gnt = 0; mem_rvalid = 1; mem_rdata = raw;
        step;
        mem_rvalid = 0; mem_rdata = 0;
        step;
    endtask

    initial begin
        #3;
        chk("rst_req_ready", {31'd0, req_ready}, 1);
        chk("rst_mem_req", {31'd0, mem_req}, 0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 0);
        step;
        rst = 0;
        step;

        push(0, 1, 0, 2);
        issue(ST, 3'b000, 32'h1003, 32'h0000_00AB, 1);
        chk("sb_req", {31'd0, mem_req}, 1);
        chk("sb_we", {31'd0, mem_we}, 1);
        chk("sb_be", {28'd0, mem_be}, 4'b1000);
        chk("sb_addr", mem_addr, 32'h1000);
        chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        mem_gnt = 1;
        step;
        mem_gnt = 0;
        chk("sb_resp_ready", {31'd0, req_ready}, 0);
        step;

        load_fast(3'b000, 32'h2001, 2, 32'h0000_8000, 32'hFFFF_FF80);
        load_fast(3'b100, 32'h2001, 2, 32'h0000_8000, 32'h0000_0080);
        load_fast(3'b101, 32'h2002, 9, 32'hBEEF_0000, 32'h0000_BEEF);
        load_fast(3'b010, 32'h2004, 10, 32'h1234_5678, 32'h1234_5678);

        push(0, 3, 1, 1);
        issue(LD, 3'b010, 32'h3002, 0, 3);
        chk("lw_mis_noreq", {31'd0, mem_req}, 0);
        step;
        push(0, 11, 1, 1);
        issue(ST, 3'b001, 32'h9001, 32'h1234, 11);
        chk("sh_mis_noreq", {31'd0, mem_req}, 0);
        step;
        push(0, 12, 1, 1);
        issue(LD, 3'b011, 32'h3000, 0, 12);
        chk("f3_011_noreq", {31'd0, mem_req}, 0);
        step;

        push(32'hFFFF_9ABC, 4, 0, 7);
        issue(LD, 3'b001, 32'h4002, 0, 4);
        for (int i = 0; i < 4; i++) begin
            chk("lh_req_held", {31'd0, mem_req}, 1);
            chk("lh_addr_held", mem_addr, 32'h4000);
            chk("lh_be_held", {28'd0, mem_be}, 4'b1100);
            chk("lh_we_held", {31'd0, mem_we}, 0);
            chk("lh_not_ready", {31'd0, req_ready}, 0);
            if (i < 3) step;
        end
        mem_gnt = 1;
        step;
        mem_gnt = 0;
        chk("lh_wait_noreq", {31'd0, mem_req}, 0);
        chk("lh_wait_ready", {31'd0, req_ready}, 0);
        step;
        mem_rvalid = 1; mem_rdata = 32'h9ABC_1234;
        step;
        mem_rvalid = 0; mem_rdata = 0;
        chk("lh_resp_ready", {31'd0, req_ready}, 0);
        step;

        issue(LD, 3'b010, 32'h5000, 0, 5);
        mem_gnt = 1;
        step;
        mem_gnt = 0; flush = 1;
        step;
        flush = 0; mem_rvalid = 1; mem_rdata = 32'hDEAD_BEEF;
        step;
        mem_rvalid = 0; mem_rdata = 0;
        push(0, 6, 0, 2);
        issue(ST, 3'b010, 32'h6000, 32'h1122_3344, 6);
        chk("sw_be", {28'd0, mem_be}, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'h1122_3344);
        mem_gnt = 1;
        step;
        mem_gnt = 0;
        step;

        issue(ST, 3'b001, 32'h7002, 32'h0000_CAFE, 7);
        flush = 1;
        step;
        flush = 0;
        chk("st_drop_ready", {31'd0, req_ready}, 1);
        chk("st_drop_noreq", {31'd0, mem_req}, 0);
        push(0, 7, 0, 2);
        issue(ST, 3'b001, 32'h7002, 32'h0000_CAFE, 7);
        chk("sh_be", {28'd0, mem_be}, 4'b1100);
        chk("sh_wdata", mem_wdata, 32'hCAFE_CAFE);
        mem_gnt = 1; flush = 1;
        step;
        mem_gnt = 0; flush = 0;
        step;

        req_valid = 1; opcode = 5'b01100;
        step;
        req_valid = 0; opcode = 0;
        chk("bad_op_ready", {31'd0, req_ready}, 1);
        chk("bad_op_noreq", {31'd0, mem_req}, 0);

        issue(LD, 3'b010, 32'h8000, 0, 8);
        mem_gnt = 1;
        step;
        mem_gnt = 0;
        rst = 1;
        #1;
        chk("arst_ready", {31'd0, req_ready}, 1);
        chk("arst_mem_req", {31'd0, mem_req}, 0);
        chk("arst_resp_valid", {31'd0, resp_valid}, 0);
        chk("arst_mem_addr", mem_addr, 0);
        #1;
        rst = 0;
        step;
        mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        step;
        mem_rvalid = 0; mem_rdata = 0;
        chk("late_rvalid_ready", {31'd0, req_ready}, 1);
        repeat (3) step;
        chk("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
